gcd_seq_engine: RTL and testbench

//  Multi-cycle Euclidean GCD engine (subtraction form, one subtract per clock) for unsigned

---
 rtl/gcd_seq_engine.sv | 103 ++++++++++
 tb/tb_gcd_seq_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_seq_engine.sv
// Multi-cycle subtractive Euclidean GCD engine with valid/ready on both sides.
// Optional iteration counter port out_iter enabled by defining GCD_ITER_CNT_EN.
module gcd_seq_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] out_iter
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Acceptance is purely a decode of the registered state
    assign in_ready = (state == IDLE);

    // Job FSM: capture operands, one subtract per clock, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= in_a;
                        b     <= in_b;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (a == '0) begin
                        out_gcd   <= b;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (b == '0) begin
                        out_gcd   <= a;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (a == b) begin
                        out_gcd   <= a;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] iter;

    assign out_iter = iter;

    // Count subtract cycles of the current job; cleared when a job is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter <= '0;
        end else if (state == IDLE && in_valid) begin
            iter <= '0;
        end else if (state == CALC && a != '0 && b != '0 && a != b) begin
            iter <= iter + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_seq_engine.sv
// Directed self-checking bench for gcd_seq_engine (WIDTH=8 and WIDTH=16 instances).
// Iteration counter checks are compiled in when GCD_ITER_CNT_EN is defined.
module tb_gcd_seq_engine;

    logic        clk;
    logic        rst_n;
    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8, g8;
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, g16;
`ifdef GCD_ITER_CNT_EN
    logic [7:0]  it8;
    logic [15:0] it16;
`endif

    int n_checks;
    int n_fails;

    gcd_seq_engine #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_gcd   (g8)
`ifdef GCD_ITER_CNT_EN
        ,
        .out_iter  (it8)
`endif
    );

    gcd_seq_engine #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_a      (a16),
        .in_b      (b16),
        .out_valid (ov16),
        .out_ready (or16),
        .out_gcd   (g16)
`ifdef GCD_ITER_CNT_EN
        ,
        .out_iter  (it16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Modulo-form Euclid, independent of the subtractive datapath
    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtraction count derived from Euclid quotients
    function automatic int ref_subs(input int x, input int y);
        int cnt, t;
        cnt = 0;
        if (x == 0 || y == 0) return 0;
        forever begin
            if (x < y) begin
                t = x;
                x = y;
                y = t;
            end
            if (x % y == 0) return cnt + x / y - 1;
            cnt += x / y;
            x = x % y;
        end
    endfunction

    function automatic logic sel_ov(input bit wide);
        return wide ? ov16 : ov8;
    endfunction

    function automatic logic sel_ir(input bit wide);
        return wide ? ir16 : ir8;
    endfunction

    function automatic logic [31:0] sel_g(input bit wide);
        return wide ? 32'(g16) : 32'(g8);
    endfunction

`ifdef GCD_ITER_CNT_EN
    function automatic logic [31:0] sel_it(input bit wide);
        return wide ? 32'(it16) : 32'(it8);
    endfunction
`endif

    // Entered #1 after an edge with the engine idle and out_ready=1
    task automatic job(input string tag, input bit wide, input int x,
                       input int y, input int exp_g, input int exp_n);
        int  cyc;
        bit  ready_hi;
        if (wide) begin
            a16 = 16'(x); b16 = 16'(y); iv16 = 1'b1;
        end else begin
            a8 = 8'(x); b8 = 8'(y); iv8 = 1'b1;
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        iv16 = 1'b0;
        a8 = 8'hA5;
        b8 = 8'h5A;
        a16 = 16'hBEEF;
        b16 = 16'h1234;
        cyc = 0;
        ready_hi = 1'b0;
        if (sel_ir(wide)) ready_hi = 1'b1;
        while (!sel_ov(wide) && cyc < 70000) begin
            @(posedge clk); #1;
            cyc++;
            if (sel_ir(wide)) ready_hi = 1'b1;
        end
        check({tag, "_latency"}, cyc, exp_n);
        check({tag, "_gcd"}, sel_g(wide), exp_g);
        check({tag, "_busy_ready"}, 32'(ready_hi), 0);
`ifdef GCD_ITER_CNT_EN
        check({tag, "_iter"}, sel_it(wide), exp_n - 1);
`endif
        @(posedge clk); #1;
        check({tag, "_drop_valid"}, 32'(sel_ov(wide)), 0);
        check({tag, "_idle_ready"}, 32'(sel_ir(wide)), 1);
    endtask

    initial begin
        int  cyc, x, y;
        bit  held_ok, ready_hi;
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov8), 0);
        check("rst_out_gcd", 32'(g8), 0);
        check("rst_in_ready", 32'(ir8), 1);
`ifdef GCD_ITER_CNT_EN
        check("rst_out_iter", 32'(it8), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        job("g12_8", 0, 12, 8, 4, 3);
        job("g0_9", 0, 0, 9, 9, 1);
        job("g9_0", 0, 9, 0, 9, 1);
        job("g0_0", 0, 0, 0, 0, 1);
        job("g7_7", 0, 7, 7, 7, 1);
        job("g255_1", 0, 255, 1, 1, 255);

        // Result back-pressure with stray in_valid pulses
        or8 = 1'b0;
        a8 = 8'd48; b8 = 8'd18; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", cyc, 5);
        check("bp_gcd", 32'(g8), 6);
        held_ok = 1'b1;
        ready_hi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iv8 = ~iv8;
            a8 = 8'(3 + i);
            b8 = 8'd9;
            @(posedge clk); #1;
            if (ov8 !== 1'b1 || g8 !== 8'd6) held_ok = 1'b0;
            if (ir8) ready_hi = 1'b1;
        end
        iv8 = 1'b0;
        check("bp_held", 32'(held_ok), 1);
        check("bp_ready_low", 32'(ready_hi), 0);
        or8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(ov8), 0);
        check("bp_release_ready", 32'(ir8), 1);
        check("bp_gcd_kept", 32'(g8), 6);

        // Abort a long job with reset
        a8 = 8'd255; b8 = 8'd1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(ov8), 0);
        check("abort_gcd", 32'(g8), 0);
        check("abort_ready", 32'(ir8), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        job("g21_14", 0, 21, 14, 7, 3);

        // Wide instance, directed
        job("w1000_600", 1, 1000, 600, 200, 4);
        job("w65535_65535", 1, 65535, 65535, 65535, 1);
        job("w0_40000", 1, 0, 40000, 40000, 1);
        job("w300_45", 1, 300, 45, 15, 9);

        // Wide instance, random operands against a modulo Euclid model
        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(500, 1));
            y = int'($urandom_range(500, 1));
            job($sformatf("wr%0d", i), 1, x, y, ref_gcd(x, y),
                ref_subs(x, y) + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
